// File: rtl/bitstream_pkg.sv
// Shared types, LFSR constants and stochastic-number-generator helpers
// for the bitstream network engine.
package bitstream_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam int unsigned LFSR_W = 16;

  // x^16+x^14+x^13+x^11+1 as a right-shifting Fibonacci register: taps on bits 0,2,3,5
  localparam logic [LFSR_W-1:0] LFSR_POLY_TAPS = 16'h002D;
  localparam logic [LFSR_W-1:0] LFSR_SEED_A    = 16'hACE1;
  localparam logic [LFSR_W-1:0] LFSR_SEED_B    = 16'h1D2C;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {^(s & LFSR_POLY_TAPS), s[LFSR_W-1:1]};
  endfunction

  // Each generator sees its own rotation of the shared LFSR so streams decorrelate
  function automatic logic sng_bit(input logic [LFSR_W-1:0] lfsr,
                                   input int unsigned       k,
                                   input logic [LFSR_W-1:0] value,
                                   input int unsigned       val_w);
    logic [2*LFSR_W-1:0] dbl;
    logic [LFSR_W-1:0]   rot;
    logic [LFSR_W-1:0]   mask;
    int unsigned         sh;
    sh   = (3 * k) % LFSR_W;
    dbl  = {lfsr, lfsr} << sh;
    rot  = dbl[2*LFSR_W-1:LFSR_W];
    mask = 16'((32'd1 << val_w) - 32'd1);
    return (rot & mask) < value;
  endfunction

endpackage

// File: rtl/bitstream_mlp_engine_if.sv
// Start/result handshake and weight-programming bus of the bitstream engine.
interface bitstream_mlp_engine_if #(
  parameter int unsigned N_IN       = 2,
  parameter int unsigned N_HID      = 2,
  parameter int unsigned N_OUT      = 1,
  parameter int unsigned STREAM_LEN = 128,
  parameter int unsigned VAL_W      = 8
);
  localparam int unsigned CNT_W  = $clog2(STREAM_LEN + 1);
  localparam int unsigned ADDR_W = $clog2(N_HID * N_IN + N_OUT * N_HID);

  logic                    start;
  logic [N_IN*VAL_W-1:0]   in_vals;
  logic                    wt_we;
  logic [ADDR_W-1:0]       wt_addr;
  logic [VAL_W-1:0]        wt_data;
  logic                    busy;
  logic                    out_valid;
  logic                    out_ready;
  logic [N_OUT*CNT_W-1:0]  out_counts;

  modport master (
    output start, in_vals, wt_we, wt_addr, wt_data, out_ready,
    input  busy, out_valid, out_counts
  );

  modport slave (
    input  start, in_vals, wt_we, wt_addr, wt_data, out_ready,
    output busy, out_valid, out_counts
  );

endinterface

// File: rtl/sc_neuron.sv
// Stochastic neuron: weight SNGs, AND multiply per input, and a
// round-robin MUX that forwards the selected product as the scaled sum.
module sc_neuron
  import bitstream_pkg::*;
#(
  parameter int unsigned FANIN   = 2,
  parameter int unsigned VAL_W   = 8,
  parameter int unsigned WT_BASE = 0
) (
  input  logic [FANIN-1:0]                            in_bits,
  input  logic [FANIN*VAL_W-1:0]                      wts,
  input  logic [LFSR_W-1:0]                           lfsr,
  input  logic [((FANIN > 1) ? $clog2(FANIN) : 1)-1:0] sel,
  output logic                                        out_bit_c
);

  localparam int unsigned SEL_W = (FANIN > 1) ? $clog2(FANIN) : 1;

  always_comb begin
    out_bit_c = 1'b0;
    for (int unsigned i = 0; i < FANIN; i++) begin
      if (sel == SEL_W'(i)) begin
        out_bit_c = in_bits[i] &
                    sng_bit(lfsr, WT_BASE + i, 16'(wts[i*VAL_W +: VAL_W]), VAL_W);
      end
    end
  end

endmodule

// File: rtl/bitstream_mlp_engine.sv
// Two-layer stochastic-computing network: control FSM, weight registers,
// LFSRs, select/run counters and per-output ones counters.
module bitstream_mlp_engine
  import bitstream_pkg::*;
#(
  parameter int unsigned N_IN       = 2,
  parameter int unsigned N_HID      = 2,
  parameter int unsigned N_OUT      = 1,
  parameter int unsigned STREAM_LEN = 128,
  parameter int unsigned VAL_W      = 8
) (
  input logic                   clk,
  input logic                   rst,
  bitstream_mlp_engine_if.slave bus
);

  localparam int unsigned CNT_W  = $clog2(STREAM_LEN + 1);
  localparam int unsigned RUN_W  = $clog2(STREAM_LEN + 1);
  localparam int unsigned N_W1   = N_HID * N_IN;
  localparam int unsigned N_WT   = N_W1 + N_OUT * N_HID;
  localparam int unsigned SEL1_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int unsigned SEL2_W = (N_HID > 1) ? $clog2(N_HID) : 1;

  logic                rst_i;
  logic [1:0]          rst_sync;
  state_t              state, next_state;
  logic                busy_d, out_valid_d, busy_q, out_valid_q;
  logic                accept_c, run_last_c, handshake_c, wt_wr_c;
  logic [VAL_W-1:0]    wt_q [N_WT];
  logic [VAL_W-1:0]    x_q  [N_IN];
  logic [LFSR_W-1:0]   lfsr_a, lfsr_b;
  logic [RUN_W-1:0]    run_cnt;
  logic [SEL1_W-1:0]   sel1;
  logic [SEL2_W-1:0]   sel2;
  logic [N_IN-1:0]     x_bits_c;
  logic [N_HID-1:0]    h_bits_c, hreg;
  logic [N_OUT-1:0]    o_bits_c;
  logic [CNT_W-1:0]    cnt_q [N_OUT];

  // Reset asserts immediately, releases two clocks after rst falls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_sync <= 2'b11;
    else     rst_sync <= {rst_sync[0], 1'b0};
  end
  assign rst_i = rst_sync[1];

  assign accept_c    = (state == IDLE) && bus.start;
  assign run_last_c  = (state == RUN) && (run_cnt == RUN_W'(STREAM_LEN));
  assign handshake_c = (state == HOLD) && out_valid_q && bus.out_ready;
  assign wt_wr_c     = (state == IDLE) && bus.wt_we && (32'(bus.wt_addr) < N_WT);

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state       <= next_state;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept_c)    next_state = LOAD;
      LOAD:                     next_state = RUN;
      RUN:     if (run_last_c)  next_state = HOLD;
      HOLD:    if (handshake_c) next_state = IDLE;
      default:                  next_state = IDLE;
    endcase
  end

  // out_valid drops on the accepting edge so a result is never taken twice
  always_comb begin
    busy_d      = (state == LOAD) || (state == RUN);
    out_valid_d = (state == HOLD) && !handshake_c;
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned k = 0; k < N_WT; k++) wt_q[k] <= '0;
    end else if (wt_wr_c) begin
      wt_q[bus.wt_addr] <= bus.wt_data;
    end
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < N_IN; i++)  x_q[i]   <= '0;
      for (int unsigned o = 0; o < N_OUT; o++) cnt_q[o] <= '0;
      lfsr_a  <= LFSR_SEED_A;
      lfsr_b  <= LFSR_SEED_B;
      run_cnt <= '0;
      sel1    <= '0;
      sel2    <= '0;
      hreg    <= '0;
    end else begin
      if (accept_c) begin
        for (int unsigned i = 0; i < N_IN; i++) x_q[i] <= bus.in_vals[i*VAL_W +: VAL_W];
      end
      case (state)
        LOAD: begin
          for (int unsigned o = 0; o < N_OUT; o++) cnt_q[o] <= '0;
          lfsr_a  <= LFSR_SEED_A;
          lfsr_b  <= LFSR_SEED_B;
          run_cnt <= '0;
          sel1    <= '0;
          sel2    <= '0;
          hreg    <= '0;
        end
        RUN: begin
          lfsr_a  <= lfsr_step(lfsr_a);
          lfsr_b  <= lfsr_step(lfsr_b);
          run_cnt <= run_cnt + RUN_W'(1);
          sel1    <= (sel1 == SEL1_W'(N_IN - 1)) ? '0 : sel1 + SEL1_W'(1);
          hreg    <= h_bits_c;
          // Cycle 0 only fills the hidden-layer register
          if (run_cnt != '0) begin
            sel2 <= (sel2 == SEL2_W'(N_HID - 1)) ? '0 : sel2 + SEL2_W'(1);
            for (int unsigned o = 0; o < N_OUT; o++) begin
              if (o_bits_c[o]) cnt_q[o] <= cnt_q[o] + CNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    x_bits_c = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      x_bits_c[i] = sng_bit(lfsr_a, i, 16'(x_q[i]), VAL_W);
    end
  end

  for (genvar h = 0; h < N_HID; h++) begin : g_hid
    logic [N_IN*VAL_W-1:0] w_flat;
    for (genvar i = 0; i < N_IN; i++) begin : g_w
      assign w_flat[i*VAL_W +: VAL_W] = wt_q[h*N_IN + i];
    end
    sc_neuron #(.FANIN(N_IN), .VAL_W(VAL_W), .WT_BASE(h * N_IN)) u_neuron (
      .in_bits   (x_bits_c),
      .wts       (w_flat),
      .lfsr      (lfsr_b),
      .sel       (sel1),
      .out_bit_c (h_bits_c[h])
    );
  end

  for (genvar o = 0; o < N_OUT; o++) begin : g_out
    logic [N_HID*VAL_W-1:0] w_flat;
    for (genvar h = 0; h < N_HID; h++) begin : g_w
      assign w_flat[h*VAL_W +: VAL_W] = wt_q[N_W1 + o*N_HID + h];
    end
    sc_neuron #(.FANIN(N_HID), .VAL_W(VAL_W), .WT_BASE(N_W1 + o * N_HID)) u_neuron (
      .in_bits   (hreg),
      .wts       (w_flat),
      .lfsr      (lfsr_b),
      .sel       (sel2),
      .out_bit_c (o_bits_c[o])
    );
    assign bus.out_counts[o*CNT_W +: CNT_W] = cnt_q[o];
  end

  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;

endmodule
